// File: rtl/sccb_target.sv
// sccb_target: SCCB (I2C-like) target with a 256x8 register file.
//
// The initiator addresses the target with an 8-bit ID. Bit 0 of the ID
// selects write (0) or read (1).
//   Write: ID, then a sub-address byte that sets the pointer, then any number
//          of data bytes, each committed to register[pointer].
//   Read:  ID, then bytes from register[pointer] until the host answers NA.
// Writing sub-address 8'h12 with data bit 7 set clears every register.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   sioc      SCCB clock from the initiator (asynchronous)
//   siod_in   sensed SIOD level (asynchronous)
//   siod_oe   1 = pull SIOD low (open-drain)
//   wr_valid  one-clk pulse per committed data byte
//   wr_addr   sub-address of the committed byte
//   wr_data   committed data byte
//   dbg_addr  local read-port address
//   dbg_data  register[dbg_addr], combinational
//   busy      high while a transaction to this device is in progress
//
// Build option
//   SCCB_TARGET_AUTOINC_EN: when defined, the pointer advances (mod 256)
//   after each written or read byte. Otherwise the pointer stays fixed.
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDAT      = 4'd5,
    ST_WDAT_ACK  = 4'd6,
    ST_RDAT      = 4'd7,
    ST_RDAT_HOST = 4'd8
  } state_t;

  // Pointer step after each byte; fixed unless auto-increment is built in.
  function automatic logic [7:0] next_ptr(input logic [7:0] p);
`ifdef SCCB_TARGET_AUTOINC_EN
    return p + 8'd1;
`else
    return p;
`endif
  endfunction

  logic [SYNC_STAGES-1:0] sioc_sync_r;
  logic [SYNC_STAGES-1:0] siod_sync_r;
  logic                   sioc_d_r;
  logic                   siod_d_r;
  logic                   sioc_s;
  logic                   siod_s;
  logic                   sioc_rise_s;
  logic                   sioc_fall_s;
  logic                   start_s;
  logic                   stop_s;
  logic [7:0]             byte_next_s;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] ptr_r;
  logic [7:0] rd_byte_r;
  logic       rw_r;
  logic       ack_phase_r;
  logic [7:0] regs_r [256];

  // Synchronizers. They reset to 1 because the idle bus is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sioc_sync_r <= '1;
      siod_sync_r <= '1;
      sioc_d_r    <= 1'b1;
      siod_d_r    <= 1'b1;
    end else begin
      sioc_sync_r <= {sioc_sync_r[SYNC_STAGES-2:0], sioc};
      siod_sync_r <= {siod_sync_r[SYNC_STAGES-2:0], siod_in};
      sioc_d_r    <= sioc_s;
      siod_d_r    <= siod_s;
    end
  end

  assign sioc_s      = sioc_sync_r[SYNC_STAGES-1];
  assign siod_s      = siod_sync_r[SYNC_STAGES-1];
  assign sioc_rise_s = sioc_s & ~sioc_d_r;
  assign sioc_fall_s = ~sioc_s & sioc_d_r;
  // START and STOP require SIOC to be high on both sides of the SIOD edge.
  assign start_s     = sioc_s & sioc_d_r & siod_d_r & ~siod_s;
  assign stop_s      = sioc_s & sioc_d_r & ~siod_d_r & siod_s;
  assign byte_next_s = {shift_r[6:0], siod_s};
  assign dbg_data    = regs_r[dbg_addr];

  // Protocol FSM, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      ptr_r       <= 8'h00;
      rd_byte_r   <= 8'h00;
      rw_r        <= 1'b0;
      ack_phase_r <= 1'b0;
      siod_oe     <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      busy        <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      wr_valid <= 1'b0;
      if (start_s) begin
        // A repeated START drops any partial byte.
        state_r     <= ST_ID;
        bit_cnt_r   <= 4'd0;
        shift_r     <= 8'h00;
        ack_phase_r <= 1'b0;
        siod_oe     <= 1'b0;
        busy        <= 1'b0;
      end else if (stop_s) begin
        state_r     <= ST_IDLE;
        bit_cnt_r   <= 4'd0;
        shift_r     <= 8'h00;
        ack_phase_r <= 1'b0;
        siod_oe     <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            siod_oe <= 1'b0;
          end
          ST_ID: begin
            if (sioc_rise_s) begin
              shift_r <= byte_next_s;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                if (byte_next_s[7:1] == DEV_ID[7:1]) begin
                  rw_r    <= byte_next_s[0];
                  busy    <= 1'b1;
                  state_r <= ST_ID_ACK;
                end else begin
                  state_r <= ST_IDLE;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_SUB, ST_WDAT: begin
            if (sioc_rise_s) begin
              shift_r <= byte_next_s;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                if (state_r == ST_SUB) begin
                  ptr_r   <= byte_next_s;
                  state_r <= ST_SUB_ACK;
                end else begin
                  wr_valid <= 1'b1;
                  wr_addr  <= ptr_r;
                  wr_data  <= byte_next_s;
                  if ((ptr_r == 8'h12) && byte_next_s[7]) begin
                    for (int i = 0; i < 256; i++) begin
                      regs_r[i] <= 8'h00;
                    end
                  end else begin
                    regs_r[ptr_r] <= byte_next_s;
                  end
                  ptr_r   <= next_ptr(ptr_r);
                  state_r <= ST_WDAT_ACK;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_ID_ACK, ST_SUB_ACK, ST_WDAT_ACK: begin
            // The first falling edge starts the ACK bit; the second ends it.
            if (sioc_fall_s) begin
              if (!ack_phase_r) begin
                siod_oe     <= 1'b1;
                ack_phase_r <= 1'b1;
              end else begin
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                if ((state_r == ST_ID_ACK) && rw_r) begin
                  rd_byte_r <= regs_r[ptr_r];
                  siod_oe   <= ~regs_r[ptr_r][7];
                  state_r   <= ST_RDAT;
                end else if (state_r == ST_ID_ACK) begin
                  siod_oe <= 1'b0;
                  state_r <= ST_SUB;
                end else begin
                  siod_oe <= 1'b0;
                  state_r <= ST_WDAT;
                end
              end
            end
          end
          ST_RDAT: begin
            if (sioc_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (sioc_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                // Release the line so the host can answer ACK/NA.
                siod_oe     <= 1'b0;
                bit_cnt_r   <= 4'd0;
                ack_phase_r <= 1'b0;
                ptr_r       <= next_ptr(ptr_r);
                state_r     <= ST_RDAT_HOST;
              end else begin
                siod_oe <= ~rd_byte_r[3'd7 - bit_cnt_r[2:0]];
              end
            end
          end
          ST_RDAT_HOST: begin
            siod_oe <= 1'b0;
            if (sioc_rise_s) begin
              if (siod_s) begin
                state_r <= ST_IDLE;
              end else begin
                ack_phase_r <= 1'b1;
              end
            end else if (sioc_fall_s && ack_phase_r) begin
              ack_phase_r <= 1'b0;
              bit_cnt_r   <= 4'd0;
              rd_byte_r   <= regs_r[ptr_r];
              siod_oe     <= ~regs_r[ptr_r][7];
              state_r     <= ST_RDAT;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            siod_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
